// File: rtl/pkt_byte_serializer.sv
// rtl/pkt_byte_serializer.sv - packet-to-byte serializer feeding the SPI transmit path
//
// Captures a PKT_BYTES*BYTE_W packet on pkt_rec and hands it out one byte at a
// time, advancing on byte_req. All outputs come straight from registers.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   din        in   packet data, sampled when pkt_rec is accepted
//   pkt_rec    in   load strobe from the packet receiver
//   byte_req   in   consumer takes dout this cycle
//   clr_err    in   clears the sticky overrun flag
//   dout       out  current byte, 0 when dout_valid is low
//   dout_valid out  dout holds a valid byte
//   last_byte  out  dout is the final byte of the packet
//   bytes_left out  bytes not yet consumed, including the current one
//   busy       out  packet in flight
//   done       out  one-cycle pulse after the final byte was consumed
//   overrun    out  sticky: a packet arrived while one was still in flight
module pkt_byte_serializer #(
  parameter int PKT_BYTES = 3,
  parameter int BYTE_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(PKT_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PKT_BYTES*BYTE_W-1:0] din,
  input  logic                        pkt_rec,
  input  logic                        byte_req,
  input  logic                        clr_err,
  output logic [BYTE_W-1:0]           dout,
  output logic                        dout_valid,
  output logic                        last_byte,
  output logic [CNT_W-1:0]            bytes_left,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);

  localparam int PKT_W = PKT_BYTES * BYTE_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_n;
  logic [PKT_W-1:0]   shreg, shreg_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [BYTE_W-1:0]  dout_n;
  logic               valid_n, last_n, done_n, ovr_n;
  logic               load, ovr_set, take_last;

  // The byte at the output end of the shift register.
  function automatic logic [BYTE_W-1:0] head(input logic [PKT_W-1:0] v);
    if (MSB_FIRST) return v[PKT_W-1 -: BYTE_W];
    else           return v[BYTE_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      last_byte  <= 1'b0;
      bytes_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
      last_byte  <= last_n;
      bytes_left <= cnt_n;
      busy       <= (state_n == SEND);
      done       <= done_n;
      overrun    <= ovr_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = bytes_left;
    done_n    = 1'b0;
    ovr_set   = 1'b0;
    load      = 1'b0;
    take_last = 1'b0;

    case (state)
      IDLE: begin
        if (pkt_rec) load = 1'b1;
      end
      SEND: begin
        take_last = byte_req && (bytes_left == CNT_W'(1));
        if (take_last) begin
          done_n = 1'b1;
          // A packet arriving exactly as the last byte leaves is accepted
          // without an idle gap; otherwise drop back to IDLE.
          if (pkt_rec) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
          end
        end else begin
          if (pkt_rec) ovr_set = 1'b1;
          if (byte_req) begin
            shreg_n = MSB_FIRST ? (shreg << BYTE_W) : (shreg >> BYTE_W);
            cnt_n   = bytes_left - CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      state_n = SEND;
      shreg_n = din;
      cnt_n   = CNT_W'(PKT_BYTES);
    end

    valid_n = (state_n == SEND);
    dout_n  = valid_n ? head(shreg_n) : '0;
    last_n  = valid_n && (cnt_n == CNT_W'(1));
    // Setting wins over clearing in the same cycle.
    ovr_n   = ovr_set | (overrun & ~clr_err);
  end

endmodule

// File: tb/tb_pkt_byte_serializer.sv
// tb/tb_pkt_byte_serializer.sv - self-checking bench for pkt_byte_serializer
module tb_pkt_byte_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] din = '0;
  logic        pkt_rec = 1'b0;
  logic        byte_req = 1'b0;
  logic        clr_err = 1'b0;

  // inst0: 3 bytes MSB first, inst1: 3 bytes LSB first, inst2: 1 byte
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2, l0, l1, l2, b0, b1, b2, dn0, dn1, dn2, o0, o1, o2;
  logic [1:0] bl0, bl1;
  logic [0:0] bl2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pkt_byte_serializer #(.PKT_BYTES(3), .BYTE_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .pkt_rec(pkt_rec), .byte_req(byte_req),
    .clr_err(clr_err), .dout(d0), .dout_valid(v0), .last_byte(l0),
    .bytes_left(bl0), .busy(b0), .done(dn0), .overrun(o0));

  pkt_byte_serializer #(.PKT_BYTES(3), .BYTE_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .pkt_rec(pkt_rec), .byte_req(byte_req),
    .clr_err(clr_err), .dout(d1), .dout_valid(v1), .last_byte(l1),
    .bytes_left(bl1), .busy(b1), .done(dn1), .overrun(o1));

  pkt_byte_serializer #(.PKT_BYTES(1), .BYTE_W(8), .MSB_FIRST(1'b1)) u_one (
    .clk(clk), .rst(rst), .din(din[7:0]), .pkt_rec(pkt_rec), .byte_req(byte_req),
    .clr_err(clr_err), .dout(d2), .dout_valid(v2), .last_byte(l2),
    .bytes_left(bl2), .busy(b2), .done(dn2), .overrun(o2));

  // {dout, valid, last, bytes_left(4), busy, done, overrun}
  logic [16:0] act [3];
  logic [16:0] exp_v [3];
  assign act[0] = {d0, v0, l0, {2'b00, bl0}, b0, dn0, o0};
  assign act[1] = {d1, v1, l1, {2'b00, bl1}, b1, dn1, o1};
  assign act[2] = {d2, v2, l2, {3'b000, bl2}, b2, dn2, o2};

  // Reference model: each instance is a queue of bytes still to be sent.
  logic [7:0] mq [3][$];
  bit         m_ovr [3];
  bit         m_done [3];

  task automatic push_pkt(input int k);
    if (k == 2) begin
      mq[k].push_back(din[7:0]);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (k == 1) mq[k].push_back(din[8*i +: 8]);
        else        mq[k].push_back(din[8*(2-i) +: 8]);
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      m_ovr[k]  = 1'b0;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit take_last;
      bit set_ovr;
      take_last = (mq[k].size() == 1) && byte_req;
      set_ovr   = 1'b0;
      m_done[k] = 1'b0;
      if (mq[k].size() == 0) begin
        if (pkt_rec) push_pkt(k);
      end else begin
        if (pkt_rec && !take_last) set_ovr = 1'b1;
        if (byte_req) void'(mq[k].pop_front());
        if (take_last) begin
          m_done[k] = 1'b1;
          if (pkt_rec) push_pkt(k);
        end
      end
      m_ovr[k] = set_ovr ? 1'b1 : (clr_err ? 1'b0 : m_ovr[k]);
    end
  endtask

  task automatic compute_exp();
    for (int k = 0; k < 3; k++) begin
      int n;
      logic [7:0] hd;
      n  = mq[k].size();
      hd = (n > 0) ? mq[k][0] : 8'h00;
      exp_v[k] = {hd, n > 0, n == 1, 4'(n), n > 0, m_done[k], m_ovr[k]};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    compute_exp();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      din = 24'($urandom); pkt_rec = 1'($urandom); byte_req = 1'($urandom);
      clr_err = 1'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== 17'h0) begin
          bad++;
          $display("FAIL reset_hold inst%0d cyc%0d got=%h exp=%h", k, c, act[k], 17'h0);
        end
      end
    end
    pkt_rec = 0; byte_req = 0; clr_err = 0;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      byte_req = 1'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== exp_v[k] || act[k] !== 17'h0) begin
          bad++;
          $display("FAIL reset_idle inst%0d cyc%0d got=%h exp=%h", k, c, act[k], 17'h0);
        end
      end
    end
    byte_req = 0;
  endtask

  task automatic test_msb_stream();
    logic [7:0] want [3];
    want[0] = 8'hA1; want[1] = 8'hB2; want[2] = 8'hC3;
    din = 24'hA1B2C3; pkt_rec = 1; byte_req = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      pkt_rec = 0;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL msb_stream inst%0d cyc%0d got=%h exp=%h", k, c, act[k], exp_v[k]);
        end
      end
      if (c < 3) begin
        total++;
        if (d0 !== want[c] || bl0 !== 2'(3 - c) || l0 !== (c == 2)) begin
          bad++;
          $display("FAIL msb_byte cyc%0d got=%h/%0d/%b exp=%h/%0d", c, d0, bl0, l0, want[c], 3 - c);
        end
      end
      if (c == 3) begin
        total++;
        if (dn0 !== 1'b1 || b0 !== 1'b0 || v0 !== 1'b0) begin
          bad++;
          $display("FAIL msb_done got=done%b busy%b valid%b exp=done1 busy0 valid0", dn0, b0, v0);
        end
      end
    end
    byte_req = 0;
  endtask

  task automatic test_lsb_stall();
    logic [7:0] seen [$];
    logic [7:0] prev;
    prev = 8'h00;
    din = 24'hA1B2C3; pkt_rec = 1; byte_req = 0;
    for (int c = 0; c < 12; c++) begin
      byte_req = (c % 3 == 2);
      tick();
      pkt_rec = 0;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL lsb_stall inst%0d cyc%0d got=%h exp=%h", k, c, act[k], exp_v[k]);
        end
      end
      if (v1 && d1 !== prev) seen.push_back(d1);
      prev = v1 ? d1 : 8'h00;
    end
    byte_req = 0;
    total++;
    if (seen.size() != 3 || seen[0] !== 8'hC3 || seen[1] !== 8'hB2 || seen[2] !== 8'hA1) begin
      bad++;
      $display("FAIL lsb_order got=%p exp=C3,B2,A1", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen [$];
    int dones;
    bit sent2;
    dones = 0; sent2 = 0;
    din = 24'h112233; pkt_rec = 1; byte_req = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      pkt_rec = 0;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL back_to_back inst%0d cyc%0d got=%h exp=%h", k, c, act[k], exp_v[k]);
        end
      end
      if (v0) seen.push_back(d0);
      if (dn0) dones++;
      if (!sent2 && mq[0].size() == 1) begin
        din = 24'h445566; pkt_rec = 1; sent2 = 1;
      end
    end
    byte_req = 0;
    total++;
    if (seen.size() != 6 || seen[0] !== 8'h11 || seen[1] !== 8'h22 || seen[2] !== 8'h33 ||
        seen[3] !== 8'h44 || seen[4] !== 8'h55 || seen[5] !== 8'h66 || dones != 2 || o0 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_seq got=%p dones=%0d ovr=%b exp=11..66 dones=2 ovr=0", seen, dones, o0);
    end
  endtask

  task automatic test_overrun();
    // {pkt_rec, byte_req, clr_err, din}, expected inst0 {dout, overrun}
    logic [26:0] stim [8];
    logic [8:0]  want [8];
    stim[0] = {3'b001, 24'h000000}; want[0] = {8'h00, 1'b0};
    stim[1] = {3'b100, 24'hA1B2C3}; want[1] = {8'hA1, 1'b0};
    stim[2] = {3'b010, 24'h000000}; want[2] = {8'hB2, 1'b0};
    stim[3] = {3'b100, 24'hFFFFFF}; want[3] = {8'hB2, 1'b1};
    stim[4] = {3'b101, 24'hFFFFFF}; want[4] = {8'hB2, 1'b1};
    stim[5] = {3'b001, 24'h000000}; want[5] = {8'hB2, 1'b0};
    stim[6] = {3'b010, 24'h000000}; want[6] = {8'hC3, 1'b0};
    stim[7] = {3'b010, 24'h000000}; want[7] = {8'h00, 1'b0};
    for (int c = 0; c < 8; c++) begin
      {pkt_rec, byte_req, clr_err, din} = stim[c];
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL overrun inst%0d cyc%0d got=%h exp=%h", k, c, act[k], exp_v[k]);
        end
      end
      total++;
      if ({d0, o0} !== want[c]) begin
        bad++;
        $display("FAIL overrun_msb cyc%0d got=%h/%b exp=%h/%b", c, d0, o0, want[c][8:1], want[c][0]);
      end
    end
    pkt_rec = 0; byte_req = 0; clr_err = 1;
    tick();
    clr_err = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] seen [$];
    din = 24'hA1B2C3; pkt_rec = 1; byte_req = 0;
    tick();
    pkt_rec = 0; byte_req = 1;
    tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compute_exp();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (act[k] !== 17'h0) begin
        bad++;
        $display("FAIL reset_async inst%0d got=%h exp=%h", k, act[k], 17'h0);
      end
    end
    tick();
    tick();
    rst = 1'b1; byte_req = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (act[k] !== exp_v[k] || act[k] !== 17'h0) begin
        bad++;
        $display("FAIL reset_nodone inst%0d got=%h exp=%h", k, act[k], 17'h0);
      end
    end
    din = 24'h5A6B7C; pkt_rec = 1; byte_req = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      pkt_rec = 0;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL reset_restart inst%0d cyc%0d got=%h exp=%h", k, c, act[k], exp_v[k]);
        end
      end
      if (v0) seen.push_back(d0);
    end
    byte_req = 0;
    total++;
    if (seen.size() != 3 || seen[0] !== 8'h5A || seen[1] !== 8'h6B || seen[2] !== 8'h7C) begin
      bad++;
      $display("FAIL reset_restart_seq got=%p exp=5A,6B,7C", seen);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      din      = 24'($urandom);
      pkt_rec  = ($urandom_range(0, 3) == 0);
      byte_req = ($urandom_range(0, 2) != 0);
      clr_err  = ($urandom_range(0, 9) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== exp_v[k]) begin
          bad++;
          $display("FAIL random inst%0d cyc%0d got=%h exp=%h", k, c, act[k], exp_v[k]);
        end
      end
    end
    pkt_rec = 0; byte_req = 0; clr_err = 0;
  endtask

  initial begin
    model_reset();
    compute_exp();
    test_reset();
    test_msb_stream();
    test_lsb_stall();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_byte_serializer.md
Name: pkt_byte_serializer

Overview:
Parametrised packet-to-byte serializer between the packet receiver and the SPI transmit path. Captures a PKT_BYTES-wide packet on a load strobe and presents it one byte at a time to the consumer, advancing on a per-byte request handshake. Adds bit-order mode, a remaining-byte count, a done pulse, back-to-back packet acceptance and a sticky overrun flag.

Parameters:
PKT_BYTES, 3, number of bytes per packet (>=1)
BYTE_W, 8, width of one output word
MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant byte sent first
CNT_W, $clog2(PKT_BYTES+1), width of bytes_left (derived; do not override)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
din  input  PKT_BYTES*BYTE_W  packet data, sampled on accepted pkt_rec
pkt_rec  input  1  load strobe, one-cycle pulse from packet receiver
byte_req  input  1  consumer (SPI) takes current dout this cycle
clr_err  input  1  clears overrun
dout  output  BYTE_W  current byte; forced 0 when dout_valid=0
dout_valid  output  1  dout holds a valid byte
last_byte  output  1  dout is final byte of packet (only with dout_valid)
bytes_left  output  CNT_W  bytes not yet consumed, including current
busy  output  1  state is SEND
done  output  1  one-cycle pulse after final byte consumed
overrun  output  1  sticky: pkt_rec arrived while a packet was still in flight

Behaviour:
- All outputs registered. Reset (rst=0, async): state IDLE; shift register, dout, bytes_left = 0; dout_valid, last_byte, busy, done, overrun = 0.
- States: IDLE, SEND.
- IDLE: pkt_rec=1 -> load din into shift register, bytes_left=PKT_BYTES, -> SEND. Next cycle dout = first byte (MSB_FIRST ? din[top BYTE_W] : din[BYTE_W-1:0]), dout_valid=1. Latency pkt_rec -> valid byte: 1 cycle. byte_req in IDLE ignored.
- SEND: dout held stable while byte_req=0 (stall any length). byte_req=1 and bytes_left>1: shift by BYTE_W toward output end, bytes_left-1, next byte visible next cycle.
- SEND, byte_req=1 and bytes_left==1 (last byte): done=1 next cycle; -> IDLE, dout_valid=0, dout=0, bytes_left=0, unless pkt_rec=1 in the same cycle (see below).
- last_byte = dout_valid && bytes_left==1.
- Back-to-back: pkt_rec=1 in the same cycle as last-byte consumption -> new packet loaded, stay SEND, bytes_left=PKT_BYTES, done still pulses, no overrun, no idle gap.
- pkt_rec=1 in SEND at any other time -> pkt_rec ignored, packet in flight unaffected, overrun=1 next cycle.
- overrun cleared by clr_err=1; set and clear in the same cycle -> set wins.
- PKT_BYTES=1: every accepted packet is immediately last_byte.
- Reset mid-packet: immediate abort, all outputs to reset values, no done pulse.

Test Plan:
- Reset: hold rst=0 with random inputs -> dout=0, dout_valid=0, bytes_left=0, overrun=0; release, idle 5 cycles -> outputs unchanged.
- MSB_FIRST=1, din=0xA1B2C3, pkt_rec pulse, byte_req held 1 -> dout A1,B2,C3 on consecutive cycles, bytes_left 3,2,1, last_byte with C3, done pulse one cycle after C3 consumed, busy then 0.
- MSB_FIRST=0, same din, byte_req asserted every 3rd cycle -> dout C3,B2,A1, each held stable through stall cycles.
- Back-to-back: 0x112233 then 0x445566 with pkt_rec on last-byte consume cycle -> 11,22,33,44,55,66 with no gap, done pulses after 33 and 66, overrun=0.
- Overrun: pkt_rec with din=0xFFFFFF while 0xA1B2C3 at byte B2 -> stream continues B2,C3, overrun=1 sticky; clr_err and pkt_rec both in SEND same cycle -> overrun stays 1; clr_err alone -> 0.
- Reset mid-packet after A1 consumed -> all outputs reset next edge-independent, no done; new packet after release streams correctly from first byte.
